matrix_3x3_gen: RTL and testbench

- Builds a 3x3 pixel neighbourhood from a raster 8-bit video stream for the 3x3 filter stages (average filter, etc.), which consume its matrix11..matrix33 / matrix_de / matrix_vs directly.
- Holds two line buffers (previous two lines) plus a 3-column shift window.
- Pixels outside the image (above row 0, left of column 0) read as 0.

---
 rtl/matrix_3x3_gen.sv | 161 ++++++++++++++++
 tb/tb_matrix_3x3_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: builds a 3x3 pixel neighbourhood from a raster video stream (two line buffers + 3-column window).
// Latency: 2 video_clk from video_data to matrix33; matrix_de / matrix_vs are delayed to stay aligned.
// Backpressure: none; accepts one pixel per clock while video_de is high.
//
// Ports:
//   video_clk             pixel clock, all logic on the rising edge
//   rst                   synchronous reset, active-high
//   video_vs / video_de   frame sync (rising edge starts a frame) / pixel valid
//   video_data            input pixel, DATA_W bits
//   matrix_vs / matrix_de video_vs / video_de delayed by 2 clocks
//   matrix11..matrix33    window rows (r-2, r-1, r) x columns (c-2, c-1, c); pixels outside the image read 0
module matrix_3x3_gen #(
  parameter int IMG_WIDTH = 1280,
  parameter int DATA_W    = 8
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic              video_vs,
  input  logic              video_de,
  input  logic [DATA_W-1:0] video_data,
  output logic              matrix_vs,
  output logic              matrix_de,
  output logic [DATA_W-1:0] matrix11,
  output logic [DATA_W-1:0] matrix12,
  output logic [DATA_W-1:0] matrix13,
  output logic [DATA_W-1:0] matrix21,
  output logic [DATA_W-1:0] matrix22,
  output logic [DATA_W-1:0] matrix23,
  output logic [DATA_W-1:0] matrix31,
  output logic [DATA_W-1:0] matrix32,
  output logic [DATA_W-1:0] matrix33
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);

  // Line buffers: r_lb1 holds the previous line, r_lb2 the one before it.
  // Never reset; stale contents are hidden by the row mask.
  logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] r_lb2 [IMG_WIDTH];

  logic              r_vs_d;
  logic              r_de_d;
  logic [CW-1:0]     r_col;
  logic [1:0]        r_row;

  logic              r_de_d1;
  logic              r_vs_d1;
  logic [CW-1:0]     r_col_d1;
  logic [1:0]        r_row_d1;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_up1;
  logic [DATA_W-1:0] r_up2;

  logic              w_vs_rise;
  logic              w_de_fall;
  logic [DATA_W-1:0] w_up1;
  logic [DATA_W-1:0] w_up2;

  assign w_vs_rise = video_vs & ~r_vs_d;
  assign w_de_fall = ~video_de & r_de_d;

  // Row/column position of the pixel currently on video_data.
  // A vs rising edge takes priority over the de falling edge so a new frame always starts at row 0.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_col  <= '0;
      r_row  <= '0;
    end else begin
      r_vs_d <= video_vs;
      r_de_d <= video_de;
      if (w_vs_rise) begin
        r_col <= '0;
        r_row <= '0;
      end else if (video_de) begin
        // Saturate: surplus pixels keep overwriting the last address.
        if (r_col != COL_MAX) r_col <= r_col + CW'(1);
      end else if (w_de_fall) begin
        r_col <= '0;
        if (r_row != 2'd2) r_row <= r_row + 2'd1;
      end
    end
  end

  // Line buffer update: the old lb1 entry migrates to lb2 as the new pixel lands in lb1.
  always_ff @(posedge video_clk) begin
    if (video_de && !rst) begin
      r_lb1[r_col] <= video_data;
      r_lb2[r_col] <= r_lb1[r_col];
    end
  end

  // Stage 1: capture the current pixel and the read-before-write contents of both buffers.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_de_d1  <= 1'b0;
      r_vs_d1  <= 1'b0;
      r_col_d1 <= '0;
      r_row_d1 <= '0;
      r_cur    <= '0;
      r_up1    <= '0;
      r_up2    <= '0;
    end else begin
      r_de_d1  <= video_de;
      r_vs_d1  <= video_vs;
      r_col_d1 <= r_col;
      r_row_d1 <= r_row;
      r_cur    <= video_data;
      r_up1    <= r_lb1[r_col];
      r_up2    <= r_lb2[r_col];
    end
  end

  // Lines above the top of the frame read as zero.
  assign w_up1 = (r_row_d1 == 2'd0) ? '0 : r_up1;
  assign w_up2 = (r_row_d1 <= 2'd1) ? '0 : r_up2;

  // Stage 2: 3-column shift window; the left columns are zeroed at the left image border.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      matrix_de <= 1'b0;
      matrix_vs <= 1'b0;
      matrix11  <= '0;
      matrix12  <= '0;
      matrix13  <= '0;
      matrix21  <= '0;
      matrix22  <= '0;
      matrix23  <= '0;
      matrix31  <= '0;
      matrix32  <= '0;
      matrix33  <= '0;
    end else begin
      matrix_de <= r_de_d1;
      matrix_vs <= r_vs_d1;
      if (r_de_d1) begin
        matrix13 <= w_up2;
        matrix23 <= w_up1;
        matrix33 <= r_cur;
        matrix12 <= (r_col_d1 == '0) ? '0 : matrix13;
        matrix22 <= (r_col_d1 == '0) ? '0 : matrix23;
        matrix32 <= (r_col_d1 == '0) ? '0 : matrix33;
        matrix11 <= (r_col_d1 <= CW'(1)) ? '0 : matrix12;
        matrix21 <= (r_col_d1 <= CW'(1)) ? '0 : matrix22;
        matrix31 <= (r_col_d1 <= CW'(1)) ? '0 : matrix32;
      end else begin
        matrix11 <= '0;
        matrix12 <= '0;
        matrix13 <= '0;
        matrix21 <= '0;
        matrix22 <= '0;
        matrix23 <= '0;
        matrix31 <= '0;
        matrix32 <= '0;
        matrix33 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb_matrix_3x3_gen: scenario tasks for matrix_3x3_gen (IMG_WIDTH=4) checked against an image-level model.
// Latency: outputs for input cycle n are sampled on the falling edge after clock edge n+1.
// Backpressure: none; stimulus is one entry per clock.
module tb_matrix_3x3_gen;

  localparam int W    = 4;
  localparam int MAXC = 2048;

  typedef int line_t [W];
  typedef struct {
    bit r;
    bit v;
    bit e;
    int d;
    int tag;
  } stim_t;

  logic       video_clk = 1'b0;
  logic       rst;
  logic       video_vs;
  logic       video_de;
  logic [7:0] video_data;
  logic       matrix_vs;
  logic       matrix_de;
  logic [7:0] matrix11, matrix12, matrix13;
  logic [7:0] matrix21, matrix22, matrix23;
  logic [7:0] matrix31, matrix32, matrix33;
  logic [7:0] obs [9];

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Image-level reference: lines received in the current frame plus the line in progress.
  // -1 marks a pixel whose value the design may legitimately hold as stale data.
  line_t lines[$];
  line_t cur_line;
  int    m_l;
  int    m_c;
  bit    m_pvs;
  bit    m_pde;

  int    exp_m  [MAXC][9];
  bit    exp_de [MAXC];
  bit    exp_vs [MAXC];
  int    tag    [MAXC];
  stim_t q[$];

  always #5 video_clk = ~video_clk;

  matrix_3x3_gen #(.IMG_WIDTH(W), .DATA_W(8)) dut (
    .video_clk (video_clk),
    .rst       (rst),
    .video_vs  (video_vs),
    .video_de  (video_de),
    .video_data(video_data),
    .matrix_vs (matrix_vs),
    .matrix_de (matrix_de),
    .matrix11  (matrix11),
    .matrix12  (matrix12),
    .matrix13  (matrix13),
    .matrix21  (matrix21),
    .matrix22  (matrix22),
    .matrix23  (matrix23),
    .matrix31  (matrix31),
    .matrix32  (matrix32),
    .matrix33  (matrix33)
  );

  assign obs[0] = matrix11;
  assign obs[1] = matrix12;
  assign obs[2] = matrix13;
  assign obs[3] = matrix21;
  assign obs[4] = matrix22;
  assign obs[5] = matrix23;
  assign obs[6] = matrix31;
  assign obs[7] = matrix32;
  assign obs[8] = matrix33;

  // Pixel dr lines above and dc columns left of the current position; outside the image is 0.
  function automatic int pix(int dr, int dc);
    int rr;
    int cc;
    rr = m_l - dr;
    cc = m_c - dc;
    if (rr < 0 || cc < 0) return 0;
    if (dr == 0) return cur_line[cc];
    return lines[rr][cc];
  endfunction

  // Apply one clock of stimulus and record what the window must show for it.
  task automatic cycle(input stim_t s);
    rst        = s.r;
    video_vs   = s.v;
    video_de   = s.e;
    video_data = 8'(s.d);
    tag[t]     = s.tag;
    if (s.r) begin
      if (t > 0) begin
        exp_de[t-1] = 1'b0;
        exp_vs[t-1] = 1'b0;
        for (int k = 0; k < 9; k++) exp_m[t-1][k] = 0;
      end
      exp_de[t] = 1'b0;
      exp_vs[t] = 1'b0;
      for (int k = 0; k < 9; k++) exp_m[t][k] = 0;
      m_l = 0;
      m_c = 0;
      lines.delete();
      cur_line = '{default: -1};
      m_pvs = 1'b0;
      m_pde = 1'b0;
    end else begin
      exp_vs[t] = s.v;
      exp_de[t] = s.e;
      for (int k = 0; k < 9; k++) exp_m[t][k] = 0;
      if (s.e) begin
        cur_line[m_c] = s.d;
        for (int k = 0; k < 9; k++) exp_m[t][k] = pix(2 - k / 3, 2 - k % 3);
        if (m_c < W - 1) m_c++;
      end
      if (s.v && !m_pvs) begin
        m_l = 0;
        m_c = 0;
        lines.delete();
        cur_line = '{default: -1};
      end else if (!s.e && m_pde) begin
        lines.push_back(cur_line);
        m_l++;
        m_c = 0;
        cur_line = '{default: -1};
      end
      m_pvs = s.v;
      m_pde = s.e;
    end
    @(posedge video_clk);
    t++;
    @(negedge video_clk);
  endtask

  task automatic push_line(input int base, input bit rnd, input int tag_base);
    for (int c = 0; c < W; c++)
      q.push_back('{1'b0, 1'b0, 1'b1, rnd ? int'($urandom_range(0, 255)) : base + c, tag_base + c});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b0, 1'b0, 1'b0, 0, 0});
  endtask

  task automatic test_reset();
    stim_t s;
    s = '{1'b1, 1'b0, 1'b1, 255, 0};
    for (int i = 0; i < 3; i++) begin
      cycle(s);
      for (int k = 0; k < 9; k++) begin
        total++;
        if (obs[k] !== 8'd0) begin
          bad++;
          $display("FAIL reset m%0d%0d clk=%0d got=%0d want=0", k / 3 + 1, k % 3 + 1, i, obs[k]);
        end
      end
      total++;
      if (matrix_de !== 1'b0) begin
        bad++;
        $display("FAIL reset matrix_de clk=%0d got=%b want=0", i, matrix_de);
      end
      total++;
      if (matrix_vs !== 1'b0) begin
        bad++;
        $display("FAIL reset matrix_vs clk=%0d got=%b want=0", i, matrix_vs);
      end
    end
    q.delete();
    push_idle(2);
    foreach (q[i]) cycle(q[i]);
  endtask

  task automatic test_image();
    int ref_tab [4][9];
    int ref_tag [4];
    ref_tag = '{103, 120, 121, 123};
    ref_tab = '{'{0, 0, 0,  0,  0,  0,  1,  2,  3},
                '{0, 0, 0,  0,  0, 16,  0,  0, 32},
                '{0, 0, 1,  0, 16, 17,  0, 32, 33},
                '{1, 2, 3, 17, 18, 19, 33, 34, 35}};
    q.delete();
    q.push_back('{1'b0, 1'b1, 1'b0, 0, 0});
    push_idle(1);
    for (int r = 0; r < 3; r++) begin
      push_line(16 * r, 1'b0, 100 + 10 * r);
      push_idle(2);
    end
    push_idle(1);
    foreach (q[i]) begin
      cycle(q[i]);
      if (t >= 2) begin
        for (int k = 0; k < 9; k++)
          if (exp_m[t-2][k] >= 0) begin
            total++;
            if (obs[k] !== 8'(exp_m[t-2][k])) begin
              bad++;
              $display("FAIL image m%0d%0d in_cyc=%0d got=%0d want=%0d", k / 3 + 1, k % 3 + 1, t - 2, obs[k], exp_m[t-2][k]);
            end
          end
        total++;
        if (matrix_de !== exp_de[t-2]) begin
          bad++;
          $display("FAIL image matrix_de in_cyc=%0d got=%b want=%b", t - 2, matrix_de, exp_de[t-2]);
        end
        total++;
        if (matrix_vs !== exp_vs[t-2]) begin
          bad++;
          $display("FAIL image matrix_vs in_cyc=%0d got=%b want=%b", t - 2, matrix_vs, exp_vs[t-2]);
        end
        for (int j = 0; j < 4; j++)
          if (tag[t-2] == ref_tag[j])
            for (int k = 0; k < 9; k++) begin
              total++;
              if (obs[k] !== 8'(ref_tab[j][k])) begin
                bad++;
                $display("FAIL image_point tag=%0d m%0d%0d got=%0d want=%0d", ref_tag[j], k / 3 + 1, k % 3 + 1, obs[k], ref_tab[j][k]);
              end
            end
      end
    end
  endtask

  task automatic test_frame_restart();
    int want;
    q.delete();
    push_line(0, 1'b1, 0);
    push_idle(2);
    push_line(0, 1'b1, 0);
    push_idle(2);
    q.push_back('{1'b0, 1'b1, 1'b0, 0, 0});
    push_idle(1);
    for (int c = 0; c < W; c++) q.push_back('{1'b0, 1'b0, 1'b1, 8'h80, 200 + c});
    push_idle(3);
    foreach (q[i]) begin
      cycle(q[i]);
      if (t >= 2) begin
        for (int k = 0; k < 9; k++)
          if (exp_m[t-2][k] >= 0) begin
            total++;
            if (obs[k] !== 8'(exp_m[t-2][k])) begin
              bad++;
              $display("FAIL restart m%0d%0d in_cyc=%0d got=%0d want=%0d", k / 3 + 1, k % 3 + 1, t - 2, obs[k], exp_m[t-2][k]);
            end
          end
        total++;
        if (matrix_de !== exp_de[t-2]) begin
          bad++;
          $display("FAIL restart matrix_de in_cyc=%0d got=%b want=%b", t - 2, matrix_de, exp_de[t-2]);
        end
        total++;
        if (matrix_vs !== exp_vs[t-2]) begin
          bad++;
          $display("FAIL restart matrix_vs in_cyc=%0d got=%b want=%b", t - 2, matrix_vs, exp_vs[t-2]);
        end
        if (tag[t-2] >= 202 && tag[t-2] <= 203)
          for (int k = 0; k < 9; k++) begin
            want = (k >= 6) ? 8'h80 : 0;
            total++;
            if (obs[k] !== 8'(want)) begin
              bad++;
              $display("FAIL restart_line c=%0d m%0d%0d got=%0d want=%0d", tag[t-2] - 200, k / 3 + 1, k % 3 + 1, obs[k], want);
            end
          end
      end
    end
  endtask

  task automatic test_mid_reset();
    q.delete();
    q.push_back('{1'b0, 1'b1, 1'b0, 0, 0});
    push_idle(1);
    push_line(0, 1'b1, 0);
    push_idle(2);
    push_line(0, 1'b1, 0);
    push_idle(2);
    q.push_back('{1'b0, 1'b0, 1'b1, 8'h11, 0});
    q.push_back('{1'b1, 1'b0, 1'b1, 8'h22, 0});
    q.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 0});
    q.push_back('{1'b0, 1'b0, 1'b1, 8'h44, 0});
    push_idle(2);
    push_line(0, 1'b1, 0);
    push_idle(2);
    push_line(0, 1'b1, 0);
    push_idle(3);
    foreach (q[i]) begin
      cycle(q[i]);
      if (q[i].r) begin
        for (int k = 0; k < 9; k++) begin
          total++;
          if (obs[k] !== 8'd0) begin
            bad++;
            $display("FAIL midreset_zero m%0d%0d got=%0d want=0", k / 3 + 1, k % 3 + 1, obs[k]);
          end
        end
      end
      if (t >= 2) begin
        for (int k = 0; k < 9; k++)
          if (exp_m[t-2][k] >= 0) begin
            total++;
            if (obs[k] !== 8'(exp_m[t-2][k])) begin
              bad++;
              $display("FAIL midreset m%0d%0d in_cyc=%0d got=%0d want=%0d", k / 3 + 1, k % 3 + 1, t - 2, obs[k], exp_m[t-2][k]);
            end
          end
        total++;
        if (matrix_de !== exp_de[t-2]) begin
          bad++;
          $display("FAIL midreset matrix_de in_cyc=%0d got=%b want=%b", t - 2, matrix_de, exp_de[t-2]);
        end
        total++;
        if (matrix_vs !== exp_vs[t-2]) begin
          bad++;
          $display("FAIL midreset matrix_vs in_cyc=%0d got=%b want=%b", t - 2, matrix_vs, exp_vs[t-2]);
        end
      end
    end
  endtask

  task automatic test_random();
    q.delete();
    for (int f = 0; f < 3; f++) begin
      q.push_back('{1'b0, 1'b1, 1'b0, 0, 0});
      push_idle(int'($urandom_range(1, 2)));
      for (int l = 0; l < int'($urandom_range(3, 5)); l++) begin
        push_line(0, 1'b1, 0);
        push_idle(int'($urandom_range(1, 3)));
      end
    end
    push_idle(2);
    foreach (q[i]) begin
      cycle(q[i]);
      if (t >= 2) begin
        for (int k = 0; k < 9; k++)
          if (exp_m[t-2][k] >= 0) begin
            total++;
            if (obs[k] !== 8'(exp_m[t-2][k])) begin
              bad++;
              $display("FAIL random m%0d%0d in_cyc=%0d got=%0d want=%0d", k / 3 + 1, k % 3 + 1, t - 2, obs[k], exp_m[t-2][k]);
            end
          end
        total++;
        if (matrix_de !== exp_de[t-2]) begin
          bad++;
          $display("FAIL random matrix_de in_cyc=%0d got=%b want=%b", t - 2, matrix_de, exp_de[t-2]);
        end
        total++;
        if (matrix_vs !== exp_vs[t-2]) begin
          bad++;
          $display("FAIL random matrix_vs in_cyc=%0d got=%b want=%b", t - 2, matrix_vs, exp_vs[t-2]);
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    video_vs   = 1'b0;
    video_de   = 1'b0;
    video_data = 8'd0;
    m_l        = 0;
    m_c        = 0;
    m_pvs      = 1'b0;
    m_pde      = 1'b0;
    cur_line   = '{default: -1};
    test_reset();
    test_image();
    test_frame_restart();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
